// File: rtl/nv_nvdla_hls_expand_pipe.sv
// nv_nvdla_hls_expand_pipe
// Two-stage valid/ready widening pipe. It takes a signed narrow operand and a
// left-shift request, and produces the sign-extended, left-scaled wide value.
// The shift is clamped to the headroom OUT_WIDTH-IN_WIDTH, so the result is
// always exact. Clamped beats are flagged and counted.
module nv_nvdla_hls_expand_pipe #(
  parameter int IN_WIDTH    = 32,
  parameter int OUT_WIDTH   = 49,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                   nvdla_core_clk,
  input  logic                   nvdla_core_rstn,
  input  logic                   in_pvld,
  output logic                   in_prdy,
  input  logic [IN_WIDTH-1:0]    in_pd,
  input  logic [SHIFT_WIDTH-1:0] in_shift,
  output logic                   out_pvld,
  input  logic                   out_prdy,
  output logic [OUT_WIDTH-1:0]   out_pd,
  output logic                   out_clip,
  output logic [15:0]            clip_cnt
);

  // Headroom between the narrow and wide domains. Shifting by more than this
  // would push significant bits out of the top of the result.
  localparam int                     MAXS   = OUT_WIDTH - IN_WIDTH;
  localparam logic [SHIFT_WIDTH-1:0] MAXS_S = SHIFT_WIDTH'(MAXS);

  logic                   s1_vld;
  logic [IN_WIDTH-1:0]    s1_pd;
  logic [SHIFT_WIDTH-1:0] s1_shift;
  logic                   s1_clip;

  logic                   s2_vld;
  logic [OUT_WIDTH-1:0]   s2_pd;
  logic                   s2_clip;

  logic                   s1_rdy;
  logic                   s2_rdy;
  logic                   in_xfer;
  logic                   in_clip;
  logic [OUT_WIDTH-1:0]   s1_wide;

  // A stage can load when it is empty or its contents are leaving this cycle.
  // Input ready is also forced low while reset is asserted.
  assign s2_rdy  = !s2_vld | out_prdy;
  assign s1_rdy  = !s1_vld | s2_rdy;
  assign in_prdy = s1_rdy & nvdla_core_rstn;

  assign in_xfer = in_pvld & in_prdy;
  assign in_clip = in_shift > MAXS_S;

  // Sign-extend into the wide domain, then scale. The shift amount is already
  // clamped, so this cannot overflow. The vacated low bits are zero.
  assign s1_wide = {{MAXS{s1_pd[IN_WIDTH-1]}}, s1_pd} << s1_shift;

  // Stage 1 captures the operand with its clamped shift and clip flag.
  // Data only moves on a real beat, so an idle stage keeps its last value.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      s1_vld   <= 1'b0;
      s1_pd    <= '0;
      s1_shift <= '0;
      s1_clip  <= 1'b0;
    end else if (s1_rdy) begin
      s1_vld <= in_pvld;
      if (in_pvld) begin
        s1_pd    <= in_pd;
        s1_shift <= in_clip ? MAXS_S : in_shift;
        s1_clip  <= in_clip;
      end
    end
  end

  // Stage 2 holds the widened result. It stays frozen while downstream stalls,
  // so out_pd and out_clip are stable under backpressure.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      s2_vld  <= 1'b0;
      s2_pd   <= '0;
      s2_clip <= 1'b0;
    end else if (s2_rdy) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_pd   <= s1_wide;
        s2_clip <= s1_clip;
      end
    end
  end

  // Count accepted beats whose shift request had to be clamped.
  // The count sticks at all-ones instead of wrapping.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      clip_cnt <= '0;
    end else if (in_xfer && in_clip && (clip_cnt != 16'hFFFF)) begin
      clip_cnt <= clip_cnt + 16'd1;
    end
  end

  assign out_pvld = s2_vld;
  assign out_pd   = s2_pd;
  assign out_clip = s2_clip;

endmodule

// File: tb/tb_nv_nvdla_hls_expand_pipe.sv
// tb_nv_nvdla_hls_expand_pipe
// Directed table vectors and hand-written multi-cycle sequences for the
// widening pipe. Random valid/ready traffic is checked against a scoreboard.
module tb_nv_nvdla_hls_expand_pipe;

  logic        nvdla_core_clk;
  logic        nvdla_core_rstn;
  logic        in_pvld;
  logic        in_prdy;
  logic [31:0] in_pd;
  logic [4:0]  in_shift;
  logic        out_pvld;
  logic        out_prdy;
  logic [48:0] out_pd;
  logic        out_clip;
  logic [15:0] clip_cnt;

  int checks = 0;
  int errors = 0;

  nv_nvdla_hls_expand_pipe dut (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rstn(nvdla_core_rstn),
    .in_pvld        (in_pvld),
    .in_prdy        (in_prdy),
    .in_pd          (in_pd),
    .in_shift       (in_shift),
    .out_pvld       (out_pvld),
    .out_prdy       (out_prdy),
    .out_pd         (out_pd),
    .out_clip       (out_clip),
    .clip_cnt       (clip_cnt)
  );

  initial nvdla_core_clk = 1'b0;
  always #5 nvdla_core_clk = ~nvdla_core_clk;

  // Guard against a hung handshake anywhere in the run.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish, act=running req=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic [31:0] pd;
    logic [4:0]  sh;
    logic [48:0] exp_pd;
    logic        exp_clip;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: act=0x%0h req=0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic pvld, input logic [31:0] pd, input logic [4:0] sh,
                               input logic prdy);
    in_pvld  = pvld;
    in_pd    = pd;
    in_shift = sh;
    out_prdy = prdy;
  endtask

  // Called 1ns after a rising edge. Lets the inputs settle, samples both
  // handshakes and the outputs before the next edge, then advances one edge.
  task automatic tick(output bit acc, output bit otx, output logic [48:0] opd, output logic oclip);
    #2;
    acc   = in_pvld && in_prdy;
    otx   = out_pvld && out_prdy;
    opd   = out_pd;
    oclip = out_clip;
    @(posedge nvdla_core_clk);
    #1;
  endtask

  task automatic doReset();
    bit          a, o;
    logic [48:0] p;
    logic        c;
    nvdla_core_rstn = 1'b0;
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b0);
    repeat (3) tick(a, o, p, c);
    nvdla_core_rstn = 1'b1;
    #1;
  endtask

  function automatic logic [48:0] model(input logic [31:0] pd, input logic [4:0] sh);
    logic signed [31:0] sp;
    logic signed [48:0] wide;
    int                 e;
    sp   = pd;
    wide = sp;
    e    = (sh > 5'd17) ? 17 : int'(sh);
    return wide <<< e;
  endfunction

  initial begin
    bit          acc, otx;
    logic [48:0] opd;
    logic        oclip;
    logic [48:0] held;
    int          sent, got, nclip, k;
    logic [49:0] q[$];
    logic [49:0] front;
    logic [31:0] rpd;
    logic [4:0]  rsh;
    logic [15:0] exp_cnt;

    vecs[0] = '{32'h8000_0000, 5'd17, 49'h1_0000_0000_0000, 1'b0};
    vecs[1] = '{32'h7FFF_FFFF, 5'd17, 49'h0_FFFF_FFFE_0000, 1'b0};
    vecs[2] = '{32'hFFFF_FFFF, 5'd0,  49'h1_FFFF_FFFF_FFFF, 1'b0};
    vecs[3] = '{32'h0000_0001, 5'd20, 49'h0_0000_0002_0000, 1'b1};
    vecs[4] = '{32'h0000_0000, 5'd17, 49'h0_0000_0000_0000, 1'b0};
    vecs[5] = '{32'hFFFF_FFFF, 5'd17, 49'h1_FFFF_FFFE_0000, 1'b0};
    vecs[6] = '{32'h1234_5678, 5'd4,  49'h0_0001_2345_6780, 1'b0};
    vecs[7] = '{32'h8000_0000, 5'd31, 49'h1_0000_0000_0000, 1'b1};
    vecs[8] = '{32'h0000_0003, 5'd18, 49'h0_0000_0006_0000, 1'b1};
    vecs[9] = '{32'hFFFF_FFFE, 5'd1,  49'h1_FFFF_FFFF_FFFC, 1'b0};

    // Reset state: ready low during reset, everything cleared.
    nvdla_core_rstn = 1'b0;
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b1);
    repeat (3) tick(acc, otx, opd, oclip);
    checkOutput("rst_in_prdy", 64'(in_prdy), 64'd0);
    checkOutput("rst_out_pvld", 64'(out_pvld), 64'd0);
    checkOutput("rst_out_pd", 64'(out_pd), 64'd0);
    checkOutput("rst_out_clip", 64'(out_clip), 64'd0);
    checkOutput("rst_clip_cnt", 64'(clip_cnt), 64'd0);
    nvdla_core_rstn = 1'b1;
    #1;
    checkOutput("rel_in_prdy", 64'(in_prdy), 64'd1);

    // Directed single-beat vectors with a two-edge latency check.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, vecs[i].pd, vecs[i].sh, 1'b1);
      acc = 1'b0;
      for (int t = 0; t < 10 && !acc; t++) tick(acc, otx, opd, oclip);
      checkOutput($sformatf("vec%0d_accept", i), 64'(acc), 64'd1);
      applyStimulus(1'b0, 32'h0, 5'd0, 1'b1);
      checkOutput($sformatf("vec%0d_early", i), 64'(out_pvld), 64'd0);
      tick(acc, otx, opd, oclip);
      checkOutput($sformatf("vec%0d_pvld", i), 64'(out_pvld), 64'd1);
      checkOutput($sformatf("vec%0d_pd", i), 64'(out_pd), 64'(vecs[i].exp_pd));
      checkOutput($sformatf("vec%0d_clip", i), 64'(out_clip), 64'(vecs[i].exp_clip));
      tick(acc, otx, opd, oclip);
    end
    checkOutput("vec_clip_cnt", 64'(clip_cnt), 64'd3);

    // Backpressure: only two beats fit, outputs freeze, then drain in order.
    doReset();
    sent = 0;
    for (int t = 0; t < 6; t++) begin
      applyStimulus(1'b1, 32'(sent), 5'd0, 1'b0);
      tick(acc, otx, opd, oclip);
      if (acc) sent++;
    end
    checkOutput("bp_accepted", 64'(sent), 64'd2);
    checkOutput("bp_in_prdy", 64'(in_prdy), 64'd0);
    held = out_pd;
    checkOutput("bp_head", 64'(held), 64'd0);
    repeat (3) tick(acc, otx, opd, oclip);
    checkOutput("bp_stable_pd", 64'(out_pd), 64'(held));
    checkOutput("bp_stable_pvld", 64'(out_pvld), 64'd1);
    out_prdy = 1'b1;
    #1;
    checkOutput("bp_rdy_same_cycle", 64'(in_prdy), 64'd1);
    got = 0;
    for (int t = 0; t < 20 && got < 4; t++) begin
      applyStimulus(sent < 4, 32'(sent), 5'd0, 1'b1);
      tick(acc, otx, opd, oclip);
      if (otx) begin
        checkOutput($sformatf("bp_order%0d", got), 64'(opd), 64'(got));
        got++;
      end
      if (acc) sent++;
    end
    checkOutput("bp_drained", 64'(got), 64'd4);

    // Random valid/ready traffic against the scoreboard.
    doReset();
    sent = 0; got = 0; nclip = 0;
    rpd = $urandom; rsh = 5'($urandom_range(0, 31));
    for (int t = 0; t < 20000 && got < 2000; t++) begin
      applyStimulus((sent < 2000) && ($urandom_range(0, 3) != 0), rpd, rsh,
                    $urandom_range(0, 3) != 0);
      tick(acc, otx, opd, oclip);
      if (otx) begin
        if (q.size() == 0) begin
          checkOutput("rnd_spurious", 64'd1, 64'd0);
        end else begin
          front = q.pop_front();
          checkOutput("rnd_pd", 64'(opd), 64'(front[48:0]));
          checkOutput("rnd_clip", 64'(oclip), 64'(front[49]));
        end
        got++;
      end
      if (acc) begin
        q.push_back({rsh > 5'd17, model(rpd, rsh)});
        if (rsh > 5'd17) nclip++;
        sent++;
        rpd = $urandom; rsh = 5'($urandom_range(0, 31));
      end
    end
    checkOutput("rnd_count", 64'(got), 64'd2000);
    checkOutput("rnd_leftover", 64'(q.size()), 64'd0);
    exp_cnt = 16'(nclip);
    checkOutput("rnd_clip_cnt", 64'(clip_cnt), 64'(exp_cnt));

    // Reset with both stages full discards them and clears the counter.
    doReset();
    k = 0;
    for (int t = 0; t < 6; t++) begin
      applyStimulus(1'b1, 32'h55, 5'd25, 1'b0);
      tick(acc, otx, opd, oclip);
      if (acc) k++;
    end
    checkOutput("mid_full", 64'(k), 64'd2);
    checkOutput("mid_cnt_before", 64'(clip_cnt), 64'd2);
    nvdla_core_rstn = 1'b0;
    #1;
    checkOutput("mid_rst_in_prdy", 64'(in_prdy), 64'd0);
    tick(acc, otx, opd, oclip);
    checkOutput("mid_rst_pvld", 64'(out_pvld), 64'd0);
    checkOutput("mid_rst_cnt", 64'(clip_cnt), 64'd0);
    nvdla_core_rstn = 1'b1;
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b1);
    #1;
    checkOutput("mid_rel_in_prdy", 64'(in_prdy), 64'd1);
    k = 0;
    for (int t = 0; t < 5; t++) begin
      tick(acc, otx, opd, oclip);
      if (otx) k++;
    end
    checkOutput("mid_no_stale", 64'(k), 64'd0);

    // Clip counter saturation at full throughput.
    doReset();
    applyStimulus(1'b1, 32'h1, 5'd31, 1'b1);
    k = 0;
    for (int t = 0; t < 65540; t++) begin
      tick(acc, otx, opd, oclip);
      if (acc) k++;
    end
    checkOutput("sat_accepted", 64'(k), 64'd65540);
    checkOutput("sat_clip_cnt", 64'(clip_cnt), 64'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nv_nvdla_hls_expand_pipe.md
# nv_nvdla_hls_expand_pipe

Pipelined widening stage: the inverse direction of the HLS saturate/narrow path. It accepts a signed narrow operand plus a left-shift amount and produces an exact sign-extended, left-scaled wide operand. It restores 32-bit stored or streamed values to the 49-bit accumulator domain ahead of the datapath. It is a 2-stage valid/ready pipe with full throughput and backpressure, and it counts shift-range clip events.

## Interface
- IN_WIDTH, 32, narrow signed input width
- OUT_WIDTH, 49, wide signed output width; must satisfy OUT_WIDTH > IN_WIDTH
- SHIFT_WIDTH, 5, width of the shift request; must be able to encode OUT_WIDTH-IN_WIDTH
- nvdla_core_clk  input  1  sole clock; all state updates on its rising edge
- nvdla_core_rstn  input  1  reset, synchronous, active-low
- in_pvld  input  1  input valid
- in_prdy  output  1  input ready
- in_pd  input  IN_WIDTH  signed two's-complement operand
- in_shift  input  SHIFT_WIDTH  unsigned left-shift request
- out_pvld  output  1  output valid
- out_prdy  input  1  output ready
- out_pd  output  OUT_WIDTH  sign-extended, shifted result
- out_clip  output  1  in_shift exceeded MAXS for this beat; qualified by out_pvld
- clip_cnt  output  16  saturating count of accepted clipped beats

## Operation
- One clock; reset is synchronous and active-low: nvdla_core_rstn sampled low at a rising edge clears all state.
- MAXS = OUT_WIDTH-IN_WIDTH, which is 17 by default.
- An input transfer occurs on an edge where in_pvld & in_prdy. An output transfer occurs on an edge where out_pvld & out_prdy.
- Stage 1 (S1) registers in_pd, eff_shift = min(in_shift, MAXS), and clip = (in_shift > MAXS).
- Stage 2 (S2) registers out_pd = sext(S1 data to OUT_WIDTH) << eff_shift, and out_clip = S1 clip.
- Arithmetic is exact: IN_WIDTH+MAXS = OUT_WIDTH, so the shift never overflows. Bits vacated by the shift are zero. The sign bit of out_pd equals in_pd[IN_WIDTH-1], except that out_pd is 0 when in_pd is 0.
- Stage ready rule: s2_rdy = !s2_vld | out_prdy; s1_rdy = !s1_vld | s2_rdy; in_prdy = s1_rdy & nvdla_core_rstn. in_prdy is a combinational function of out_prdy by design.
- A stage loads whenever its ready is high. Its valid then takes the upstream valid, so bubbles collapse.
- While out_pvld & !out_prdy, out_pd and out_clip hold stable. S1 fills, then in_prdy drops.
- clip_cnt increments by 1 on each input transfer with in_shift > MAXS. It saturates at 0xFFFF and does not wrap. It clears only on reset.
- Simultaneous input transfer and output transfer in the same edge is a normal pipeline advance, with no loss or duplication.
- Ordering is strictly preserved, with no reordering and no drops.

## Timing
- Reset values: out_pvld=0, out_pd=0, out_clip=0, clip_cnt=0, internal S1 valid=0. in_prdy=0 while nvdla_core_rstn is low and 1 on the first cycle after release.
- Latency: a beat accepted at edge N has out_pvld high in the cycle after edge N+1, i.e. 2 edges, assuming no backpressure.
- Throughput is 1 beat per cycle with out_prdy held high.
- Capacity is 2 beats, S1 plus S2. With out_prdy low, 2 beats are accepted and then in_prdy=0 until an output transfer.
- After out_prdy rises, in_prdy rises in the same cycle.
- Reset mid-operation discards both stages with no output transfer; clip_cnt returns to 0.
- No output has a combinational path from in_pvld or in_pd. in_prdy depends combinationally on out_prdy only.

## Test plan
- in_pd=0x8000_0000, in_shift=17 -> out_pd=0x1_0000_0000_0000, out_clip=0, out_pvld 2 edges after accept.
- in_pd=0x7FFF_FFFF, in_shift=17 -> out_pd=0x0_FFFF_FFFE_0000; in_pd=0xFFFF_FFFF, in_shift=0 -> out_pd=0x1_FFFF_FFFF_FFFF.
- in_pd=0x0000_0001, in_shift=20 -> out_pd=0x0_0000_0002_0000, out_clip=1, clip_cnt=1.
- Backpressure: stream 0,1,2,3 with shift 0 while out_prdy=0 -> exactly 2 accepted and in_prdy=0. Then release out_prdy -> outputs 0,1,2,3 in order, out_pd stable while stalled.
- Random valid/ready toggling, 10k beats, against a reference model -> zero mismatches, no drops or duplicates. 70000 clipped beats -> clip_cnt=0xFFFF.
- Assert reset with both stages full -> out_pvld=0 and clip_cnt=0 on the next cycle. in_prdy=0 during reset and 1 after release, and no stale beat emerges.
